// File: rtl/vector_fifo_pkg.sv
// Shared helpers and constants for the vector_fifo block.
// The optional VECTOR_FIFO_ERR_FLAGS_EN error flags do not affect this package.
package vector_fifo_pkg;

    localparam int unsigned VEC_LANES_XYZ = 3;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Anything other than a clean 1 (including X/Z) reads back as 0.
    function automatic logic to_01(input logic b);
        return (b === 1'b1);
    endfunction

endpackage

// File: rtl/vector_fifo_if.sv
// Push/pop bus of vector_fifo. err_clr/overflow/underflow exist only when
// VECTOR_FIFO_ERR_FLAGS_EN is defined.
interface vector_fifo_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LANES      = 3,
    parameter int unsigned DEPTH      = 1000
) ();
    import vector_fifo_pkg::*;
    localparam int unsigned CNT_W = cnt_width(DEPTH);

    logic                         wr_en;
    logic signed [DATA_WIDTH-1:0] din [LANES-1:0];
    logic                         full;
    logic                         almost_full;
    logic                         rd_en;
    logic signed [DATA_WIDTH-1:0] dout [LANES-1:0];
    logic                         empty;
    logic                         almost_empty;
    logic [CNT_W-1:0]             count;
`ifdef VECTOR_FIFO_ERR_FLAGS_EN
    logic                         err_clr;
    logic                         overflow;
    logic                         underflow;
`endif

    modport master (
        output wr_en, din, rd_en,
`ifdef VECTOR_FIFO_ERR_FLAGS_EN
        output err_clr,
        input  overflow, underflow,
`endif
        input  full, almost_full, dout, empty, almost_empty, count
    );

    modport slave (
        input  wr_en, din, rd_en,
`ifdef VECTOR_FIFO_ERR_FLAGS_EN
        input  err_clr,
        output overflow, underflow,
`endif
        output full, almost_full, dout, empty, almost_empty, count
    );

endinterface

// File: rtl/vector_fifo_ctrl.sv
// Data-independent control of vector_fifo: pointers, occupancy, flags, accept
// logic, FWFT output-register valid. VECTOR_FIFO_ERR_FLAGS_EN adds sticky error flags.
module vector_fifo_ctrl import vector_fifo_pkg::*; #(
    parameter int unsigned DEPTH     = 1000,
    parameter int          AF_THRESH = int'(DEPTH) - 4,
    parameter int          AE_THRESH = 4,
    parameter bit          FWFT      = 1'b0,
    localparam int unsigned PTR_W    = ptr_width(DEPTH),
    localparam int unsigned CNT_W    = cnt_width(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_en,
    input  logic             rd_en,
`ifdef VECTOR_FIFO_ERR_FLAGS_EN
    input  logic             err_clr,
    output logic             overflow,
    output logic             underflow,
`endif
    output logic             full,
    output logic             almost_full,
    output logic             empty,
    output logic             almost_empty,
    output logic [CNT_W-1:0] count,
    output logic             mem_wr,
    output logic             mem_rd,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [PTR_W-1:0] rd_ptr
);

    if (DEPTH < 2) begin : g_bad_depth
        $error("vector_fifo: DEPTH must be at least 2");
    end
    if (AF_THRESH < 0 || AF_THRESH > int'(DEPTH)) begin : g_bad_af
        $error("vector_fifo: AF_THRESH outside 0..DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH > int'(DEPTH)) begin : g_bad_ae
        $error("vector_fifo: AE_THRESH outside 0..DEPTH");
    end

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             out_valid_q, out_valid_d;
    logic             wr_acc, rd_acc;
`ifdef VECTOR_FIFO_ERR_FLAGS_EN
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
`endif

    always_comb begin
        full         = (count_q == CNT_MAX);
        almost_full  = (count_q >= CNT_W'(AF_THRESH));
        almost_empty = (count_q <= CNT_W'(AE_THRESH));
        empty        = FWFT ? ~out_valid_q : (count_q == '0);

        wr_acc = wr_en & ~full;
        rd_acc = rd_en & ~empty;
        mem_wr = wr_acc;

        // In FWFT the memory holds count minus the output-register entry; it
        // feeds the register whenever that slot is free or being consumed.
        if (FWFT) begin
            mem_rd = (count_q != CNT_W'(out_valid_q)) & (~out_valid_q | rd_acc);
        end else begin
            mem_rd = rd_acc;
        end
        out_valid_d = FWFT ? (mem_rd | (out_valid_q & ~rd_acc)) : 1'b0;

        wr_ptr_d = wr_ptr_q;
        if (wr_acc) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        rd_ptr_d = rd_ptr_q;
        if (mem_rd) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
        end

        count_d = count_q;
        if (wr_acc && !rd_acc) begin
            count_d = count_q + CNT_W'(1);
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - CNT_W'(1);
        end

`ifdef VECTOR_FIFO_ERR_FLAGS_EN
        overflow_d  = (wr_en & full)  | (overflow_q  & ~err_clr);
        underflow_d = (rd_en & empty) | (underflow_q & ~err_clr);
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            out_valid_q <= 1'b0;
`ifdef VECTOR_FIFO_ERR_FLAGS_EN
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
`endif
        end else begin
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            out_valid_q <= out_valid_d;
`ifdef VECTOR_FIFO_ERR_FLAGS_EN
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
`endif
        end
    end

    assign count  = count_q;
    assign wr_ptr = wr_ptr_q;
    assign rd_ptr = rd_ptr_q;
`ifdef VECTOR_FIFO_ERR_FLAGS_EN
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

endmodule

// File: rtl/vector_fifo.sv
// Multi-lane vector FIFO: shared controller, LANES-wide memory, output register.
// Define VECTOR_FIFO_ERR_FLAGS_EN to add err_clr/overflow/underflow.
module vector_fifo import vector_fifo_pkg::*; #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LANES      = VEC_LANES_XYZ,
    parameter int unsigned DEPTH      = 1000,
    parameter int          AF_THRESH  = int'(DEPTH) - 4,
    parameter int          AE_THRESH  = 4,
    parameter bit          FWFT       = 1'b0
) (
    input logic          clock,
    input logic          reset,
    vector_fifo_if.slave bus
);

    localparam int unsigned PTR_W = ptr_width(DEPTH);

    if (LANES < 1) begin : g_bad_lanes
        $error("vector_fifo: LANES must be at least 1");
    end

    logic                         mem_wr, mem_rd;
    logic [PTR_W-1:0]             wr_ptr, rd_ptr;
    logic signed [DATA_WIDTH-1:0] mem_q  [DEPTH-1:0][LANES-1:0];
    logic signed [DATA_WIDTH-1:0] dout_q [LANES-1:0];
    logic signed [DATA_WIDTH-1:0] dout_d [LANES-1:0];

    vector_fifo_ctrl #(
        .DEPTH     (DEPTH),
        .AF_THRESH (AF_THRESH),
        .AE_THRESH (AE_THRESH),
        .FWFT      (FWFT)
    ) u_ctrl (
        .clock        (clock),
        .reset        (reset),
        .wr_en        (bus.wr_en),
        .rd_en        (bus.rd_en),
`ifdef VECTOR_FIFO_ERR_FLAGS_EN
        .err_clr      (bus.err_clr),
        .overflow     (bus.overflow),
        .underflow    (bus.underflow),
`endif
        .full         (bus.full),
        .almost_full  (bus.almost_full),
        .empty        (bus.empty),
        .almost_empty (bus.almost_empty),
        .count        (bus.count),
        .mem_wr       (mem_wr),
        .mem_rd       (mem_rd),
        .wr_ptr       (wr_ptr),
        .rd_ptr       (rd_ptr)
    );

    always_ff @(posedge clock) begin
        if (mem_wr) begin
            for (int unsigned l = 0; l < LANES; l++) begin
                mem_q[wr_ptr][l] <= bus.din[l];
            end
        end
    end

    always_comb begin
        for (int unsigned l = 0; l < LANES; l++) begin
            dout_d[l] = dout_q[l];
        end
        if (mem_rd) begin
            for (int unsigned l = 0; l < LANES; l++) begin
                for (int unsigned b = 0; b < DATA_WIDTH; b++) begin
                    dout_d[l][b] = to_01(mem_q[rd_ptr][l][b]);
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned l = 0; l < LANES; l++) begin
                dout_q[l] <= '0;
            end
        end else begin
            for (int unsigned l = 0; l < LANES; l++) begin
                dout_q[l] <= dout_d[l];
            end
        end
    end

    always_comb begin
        for (int unsigned l = 0; l < LANES; l++) begin
            bus.dout[l] = dout_q[l];
        end
    end

endmodule

// File: tb/tb_vector_fifo.sv
// Scoreboard bench for vector_fifo: standard-read and FWFT instances, DEPTH=5.
// Error-flag checks compile in when VECTOR_FIFO_ERR_FLAGS_EN is defined.
module tb_vector_fifo;
    localparam int DW  = 32;
    localparam int NL  = 3;
    localparam int DEP = 5;
    localparam int CW  = 3;
    typedef logic [NL*DW-1:0] pvec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vector_fifo_if #(.DATA_WIDTH(DW), .LANES(NL), .DEPTH(DEP)) if_s ();
    vector_fifo_if #(.DATA_WIDTH(DW), .LANES(NL), .DEPTH(DEP)) if_f ();

    vector_fifo #(.DATA_WIDTH(DW), .LANES(NL), .DEPTH(DEP), .AF_THRESH(1),
                  .AE_THRESH(1), .FWFT(1'b0))
        u_std (.clock(clk), .reset(rst), .bus(if_s.slave));
    vector_fifo #(.DATA_WIDTH(DW), .LANES(NL), .DEPTH(DEP), .AF_THRESH(1),
                  .AE_THRESH(1), .FWFT(1'b1))
        u_fwft (.clock(clk), .reset(rst), .bus(if_f.slave));

    logic                 wr_t  [2];
    logic                 rd_t  [2];
    logic signed [DW-1:0] din_t [2][NL];
    pvec_t                dout_p [2];
    logic [CW-1:0]        cnt_p  [2];
    logic                 full_p [2];
    logic                 empty_p [2];
    logic                 af_p [2];
    logic                 ae_p [2];

    assign if_s.wr_en = wr_t[0];
    assign if_s.rd_en = rd_t[0];
    assign if_f.wr_en = wr_t[1];
    assign if_f.rd_en = rd_t[1];
    for (genvar l = 0; l < NL; l++) begin : g_lane
        assign if_s.din[l] = din_t[0][l];
        assign if_f.din[l] = din_t[1][l];
    end
    assign dout_p[0]  = {if_s.dout[2], if_s.dout[1], if_s.dout[0]};
    assign dout_p[1]  = {if_f.dout[2], if_f.dout[1], if_f.dout[0]};
    assign cnt_p[0]   = if_s.count;
    assign cnt_p[1]   = if_f.count;
    assign full_p[0]  = if_s.full;
    assign full_p[1]  = if_f.full;
    assign empty_p[0] = if_s.empty;
    assign empty_p[1] = if_f.empty;
    assign af_p[0]    = if_s.almost_full;
    assign af_p[1]    = if_f.almost_full;
    assign ae_p[0]    = if_s.almost_empty;
    assign ae_p[1]    = if_f.almost_empty;

`ifdef VECTOR_FIFO_ERR_FLAGS_EN
    logic clr_s = 1'b0;
    assign if_s.err_clr = clr_s;
    assign if_f.err_clr = 1'b0;
`endif

    int total = 0;
    int bad   = 0;
    pvec_t ref_q [2][$];
    pvec_t exp_q [2][$];
    logic  pend_s = 1'b0;

    function automatic pvec_t mk(input int a, input int b, input int c);
        return {DW'(c), DW'(b), DW'(a)};
    endfunction

    task automatic chk(input string nm, input pvec_t act, input pvec_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_state(input int d);
        int n;
        n = ref_q[d].size();
        chk($sformatf("count%0d", d), pvec_t'(cnt_p[d]), pvec_t'(n));
        chk($sformatf("full%0d", d), pvec_t'(full_p[d]), pvec_t'(n == DEP));
        chk($sformatf("afull%0d", d), pvec_t'(af_p[d]), pvec_t'(n >= 1));
        chk($sformatf("aempty%0d", d), pvec_t'(ae_p[d]), pvec_t'(n <= 1));
        if (d == 0) chk("empty0", pvec_t'(empty_p[0]), pvec_t'(n == 0));
    endtask

    // One cycle of stimulus; expected read data enters the scoreboard here.
    task automatic step(input int d, input bit we, input bit re, input pvec_t v);
        bit wr_ok, rd_ok;
        wr_ok = we && (ref_q[d].size() < DEP);
        rd_ok = re && (ref_q[d].size() > 0);
        if (rd_ok) exp_q[d].push_back(ref_q[d].pop_front());
        if (wr_ok) ref_q[d].push_back(v);
        wr_t[d] = we;
        rd_t[d] = re;
        din_t[d][0] = v[DW-1:0];
        din_t[d][1] = v[2*DW-1:DW];
        din_t[d][2] = v[3*DW-1:2*DW];
        tick();
        wr_t[d] = 1'b0;
        rd_t[d] = 1'b0;
        chk_state(d);
    endtask

    task automatic check_out(input int d);
        pvec_t e;
        if (exp_q[d].size() == 0) begin
            total++;
            bad++;
            $display("FAIL out%0d: got %0h expected no output", d, dout_p[d]);
        end else begin
            e = exp_q[d].pop_front();
            chk($sformatf("out%0d", d), dout_p[d], e);
        end
    endtask

    // Monitor: standard mode data is checked the cycle after an accepted
    // read; FWFT data is checked while the head is being consumed.
    always @(negedge clk) begin
        if (pend_s) check_out(0);
        pend_s = !rst && rd_t[0] && !empty_p[0];
        if (!rst && rd_t[1] && !empty_p[1]) check_out(1);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            wr_t[d] = 1'b0;
            rd_t[d] = 1'b0;
            for (int l = 0; l < NL; l++) din_t[d][l] = '0;
        end
        #3;
        chk_state(0);
        chk_state(1);
        chk("rst_empty1", pvec_t'(empty_p[1]), pvec_t'(1));
        chk("rst_dout0", dout_p[0], '0);
        chk("rst_dout1", dout_p[1], '0);
`ifdef VECTOR_FIFO_ERR_FLAGS_EN
        chk("rst_ovf", pvec_t'(if_s.overflow), '0);
        chk("rst_unf", pvec_t'(if_s.underflow), '0);
`endif
        @(posedge clk);
        #2 rst = 1'b0;

        // Fill to full, one extra ignored write, then drain.
        for (int i = 1; i <= 5; i++) step(0, 1, 0, mk(i, -i, 2 * i));
        step(0, 1, 0, mk(6, -6, 12));
        for (int i = 1; i <= 5; i++) step(0, 0, 1, '0);
        tick();
        chk("dout_hold", dout_p[0], mk(5, -5, 10));
        step(0, 0, 1, '0);

        // Pointer wrap-around.
        for (int i = 11; i <= 13; i++) step(0, 1, 0, mk(i, -i, 2 * i));
        for (int i = 0; i < 3; i++) step(0, 0, 1, '0);
        for (int i = 21; i <= 25; i++) step(0, 1, 0, mk(i, -i, 2 * i));
        for (int i = 0; i < 5; i++) step(0, 0, 1, '0);

        // Simultaneous push/pop at count 2, 0 and DEPTH.
        step(0, 1, 0, mk(31, 32, 33));
        step(0, 1, 0, mk(34, 35, 36));
        step(0, 1, 1, mk(37, 38, 39));
        step(0, 0, 1, '0);
        step(0, 0, 1, '0);
        step(0, 1, 1, mk(41, -41, 82));
        for (int i = 42; i <= 45; i++) step(0, 1, 0, mk(i, -i, 2 * i));
        step(0, 1, 1, mk(99, 99, 99));
        for (int i = 0; i < 4; i++) step(0, 0, 1, '0);

        // Asynchronous reset between edges with three entries stored.
        for (int i = 51; i <= 53; i++) step(0, 1, 0, mk(i, i, i));
        rst = 1'b1;
        #1;
        ref_q[0].delete();
        ref_q[1].delete();
        chk_state(0);
        chk("midrst_dout", dout_p[0], '0);
        #1 rst = 1'b0;
        step(0, 1, 0, mk(4, 4, 4));
        step(0, 0, 1, '0);
        tick();

`ifdef VECTOR_FIFO_ERR_FLAGS_EN
        step(0, 0, 1, '0);
        chk("unf_set", pvec_t'(if_s.underflow), pvec_t'(1));
        tick();
        chk("unf_sticky", pvec_t'(if_s.underflow), pvec_t'(1));
        clr_s = 1'b1;
        tick();
        clr_s = 1'b0;
        chk("unf_clr", pvec_t'(if_s.underflow), '0);
        for (int i = 61; i <= 65; i++) step(0, 1, 0, mk(i, 0, -i));
        chk("ovf_idle", pvec_t'(if_s.overflow), '0);
        clr_s = 1'b1;
        step(0, 1, 0, mk(66, 0, -66));
        clr_s = 1'b0;
        chk("ovf_set_beats_clr", pvec_t'(if_s.overflow), pvec_t'(1));
        for (int i = 0; i < 5; i++) step(0, 0, 1, '0);
        tick();
`endif

        // FWFT: two-cycle fall-through latency, then back-to-back streaming.
        wr_t[1] = 1'b1;
        din_t[1][0] = 7;
        din_t[1][1] = 8;
        din_t[1][2] = 9;
        ref_q[1].push_back(mk(7, 8, 9));
        tick();
        wr_t[1] = 1'b0;
        chk("fwft_lat1_empty", pvec_t'(empty_p[1]), pvec_t'(1));
        chk_state(1);
        tick();
        chk("fwft_lat2_empty", pvec_t'(empty_p[1]), '0);
        chk("fwft_head", dout_p[1], mk(7, 8, 9));
        step(1, 0, 1, '0);
        chk("fwft_drained", pvec_t'(empty_p[1]), pvec_t'(1));
        for (int i = 71; i <= 74; i++) step(1, 1, 0, mk(i, -i, 2 * i));
        tick();
        tick();
        for (int i = 0; i < 4; i++) step(1, 0, 1, '0);
        chk("fwft_end_empty", pvec_t'(empty_p[1]), pvec_t'(1));

        tick();
        tick();
        chk("sb_left0", pvec_t'(exp_q[0].size()), '0);
        chk("sb_left1", pvec_t'(exp_q[1].size()), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
